// File: rtl/switch_led_debounce_bank.sv
// N-channel switch bank: each switch is synchronised and debounced before it drives an LED,
// and a one-cycle pulse marks each debounced press. Define SWITCH_LED_TOGGLE_EN to build toggle mode.
module switch_led_debounce_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Toggle_Mode,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Press_Pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0] r_Sync1;
  logic [NUM_CH-1:0] r_Sync2;
  logic [NUM_CH-1:0] r_Stable;
  logic [NUM_CH-1:0] r_LED;
  logic [NUM_CH-1:0] r_Pulse;
  logic [CNT_W-1:0]  r_Count [NUM_CH];

  logic [NUM_CH-1:0] w_StableNext;
  logic [NUM_CH-1:0] w_Rise;
  logic [NUM_CH-1:0] w_LEDNext;
  logic [CNT_W-1:0]  w_CountNext [NUM_CH];

  // A changed level must persist for DEBOUNCE_LIMIT consecutive clocks; any return restarts the count.
  always_comb begin
    w_StableNext = r_Stable;
    for (int n = 0; n < NUM_CH; n++) begin
      w_CountNext[n] = '0;
      if (r_Sync2[n] != r_Stable[n]) begin
        if (r_Count[n] == LAST_CNT) begin
          w_StableNext[n] = r_Sync2[n];
        end else begin
          w_CountNext[n] = r_Count[n] + 1'b1;
        end
      end
    end
    w_Rise = w_StableNext & ~r_Stable;
  end

`ifdef SWITCH_LED_TOGGLE_EN
  // Leaving toggle mode reloads the LED from the debounced level; entering it holds the LED.
  always_comb begin
    w_LEDNext = i_Toggle_Mode ? (r_LED ^ w_Rise) : w_StableNext;
  end
`else
  logic w_unused_ToggleMode;
  assign w_unused_ToggleMode = i_Toggle_Mode;

  always_comb begin
    w_LEDNext = w_StableNext;
  end
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Sync1  <= '0;
      r_Sync2  <= '0;
      r_Stable <= '0;
      r_LED    <= '0;
      r_Pulse  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_Count[n] <= '0;
      end
    end else begin
      r_Sync1  <= i_Switch;
      r_Sync2  <= r_Sync1;
      r_Stable <= w_StableNext;
      r_LED    <= w_LEDNext;
      r_Pulse  <= w_Rise;
      for (int n = 0; n < NUM_CH; n++) begin
        r_Count[n] <= w_CountNext[n];
      end
    end
  end

  assign o_LED         = r_LED;
  assign o_Press_Pulse = r_Pulse;

endmodule
